// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC mode arbiter: FSM state encoding,
// default timing constants and the wr_ind read/write encoding.
package rtc_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_GRANT = 2'd2
   } state_e;

   localparam int DEF_BOUNDARY    = 'h4A;
   localparam int DEF_INIT_CYCLES = 1034;
   localparam int INIT_CNT_W      = 11;

   localparam logic WR = 1'b0;
   localparam logic RD = 1'b1;

endpackage

// File: rtl/rtc_mode_arbiter_if.sv
// Bus from the mode arbiter to the RTC protocol block: address, write data,
// data drive enable and the read/write indicator.
interface rtc_mode_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic              data_oe;
   logic              wr_ind;

   modport master (output address, output data, output data_oe, output wr_ind);
   modport slave  (input  address, input  data, input  data_oe, input  wr_ind);
endinterface

// File: rtl/rtc_req_sync.sv
// Boundary-gated request sampler: fixed-priority one-hot pick (index 0 wins)
// and a sticky flag for boundaries that saw more than one request.
module rtc_req_sync
   import rtc_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int CNT_W    = 7,
   parameter int BOUNDARY = DEF_BOUNDARY
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CNT_W-1:0]   bus_cnt_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               en_i,
   output logic               sample_o,
   output logic [NUM_REQ-1:0] pick_o,
   output logic               conflict_o
);

   logic multi;
   logic seen;
   logic conflict_q;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      pick_o = '0;
      multi  = 1'b0;
      seen   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_i[i]) begin
            if (seen) multi = 1'b1;
            else      pick_o[i] = 1'b1;
            seen = 1'b1;
         end
      end
   end

   assign sample_o = en_i && (bus_cnt_i == CNT_W'(BOUNDARY));

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                conflict_q <= 1'b0;
      else if (sample_o && multi) conflict_q <= 1'b1;
   end

   assign conflict_o = conflict_q;

endmodule

// File: rtl/rtc_mode_arbiter.sv
// RTC mode arbiter: timed power-up INIT, default register reading, and
// boundary-sampled request grants driving the protocol bus.
// Optional alarm (ring) logic is built only when RTC_ALARM_EN is defined.
module rtc_mode_arbiter
   import rtc_pkg::*;
#(
   parameter int                 NUM_REQ        = 4,
   parameter int                 ADDR_W         = 8,
   parameter int                 DATA_W         = 8,
   parameter int                 CNT_W          = 7,
   parameter int                 BOUNDARY       = DEF_BOUNDARY,
   parameter int                 INIT_CYCLES    = DEF_INIT_CYCLES,
   parameter int                 SOFT_RST_IDX   = 0,
   parameter logic [NUM_REQ-1:0] ZERO_ADDR_MASK = 4'b0100,
   parameter int                 ALARM_CLR_IDX  = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CNT_W-1:0]          bus_cnt,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [ADDR_W-1:0]         addr_init,
   input  logic [DATA_W-1:0]         data_init,
   input  logic [ADDR_W-1:0]         addr_read,
   input  logic [NUM_REQ*ADDR_W-1:0] addr_req,
   input  logic [NUM_REQ*DATA_W-1:0] data_req,
   input  logic [DATA_W-1:0]         cmp_a,
   input  logic [DATA_W-1:0]         cmp_b,
   input  logic [DATA_W-1:0]         alarm_a,
   input  logic [DATA_W-1:0]         alarm_b,
   rtc_mode_arbiter_if.master        bus,
   output logic                      init_active,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      conflict,
   output logic                      ring
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);

   state_e                  state_q;
   logic [INIT_CNT_W-1:0]   init_cnt_q;
   logic [NUM_REQ-1:0]      grant_q;
   logic                    init_active_q;
   logic                    sample;
   logic [NUM_REQ-1:0]      pick;
   logic [IDX_W-1:0]        grant_idx;
   logic [ADDR_W-1:0]       sel_addr;

   rtc_req_sync #(
      .NUM_REQ  (NUM_REQ),
      .CNT_W    (CNT_W),
      .BOUNDARY (BOUNDARY)
   ) u_req_sync (
      .clk        (clk),
      .reset      (reset),
      .bus_cnt_i  (bus_cnt),
      .req_i      (req),
      .en_i       (state_q != ST_INIT),
      .sample_o   (sample),
      .pick_o     (pick),
      .conflict_o (conflict)
   );

   // A held grant survives boundaries; only a dropped request hands over.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_INIT;
         init_cnt_q    <= '0;
         grant_q       <= '0;
         init_active_q <= 1'b1;
      end else begin
         case (state_q)
            ST_INIT: begin
               if (init_cnt_q == INIT_LAST) begin
                  state_q       <= ST_IDLE;
                  init_active_q <= 1'b0;
               end else begin
                  init_cnt_q <= init_cnt_q + 1'b1;
               end
            end
            ST_IDLE: begin
               if (sample && (req != '0)) begin
                  state_q <= ST_GRANT;
                  grant_q <= pick;
               end
            end
            ST_GRANT: begin
               if (sample && ((req & grant_q) == '0)) begin
                  if (req == '0) begin
                     state_q <= ST_IDLE;
                     grant_q <= '0;
                  end else begin
                     grant_q <= pick;
                  end
               end
            end
            default: state_q <= ST_INIT;
         endcase
      end
   end

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant_q[i]) grant_idx = IDX_W'(i);
   end

   always_comb begin
      bus.address  = addr_read;
      bus.data     = '0;
      bus.data_oe  = 1'b0;
      bus.wr_ind   = RD;
      sel_addr     = addr_req[grant_idx*ADDR_W +: ADDR_W];
      case (state_q)
         ST_INIT: begin
            bus.address = addr_init;
            bus.data    = data_init;
            bus.data_oe = 1'b1;
            bus.wr_ind  = WR;
         end
         ST_GRANT: begin
            bus.wr_ind = WR;
            if (grant_idx == IDX_W'(SOFT_RST_IDX)) begin
               bus.address = addr_init;
               bus.data    = data_init;
               bus.data_oe = 1'b1;
            end else begin
               bus.address = sel_addr;
               // Masked channels only write data to address zero.
               if (!(ZERO_ADDR_MASK[grant_idx] && (sel_addr != '0))) begin
                  bus.data    = data_req[grant_idx*DATA_W +: DATA_W];
                  bus.data_oe = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

`ifdef RTC_ALARM_EN
   logic ring_q;
   logic alarm_hit;

   assign alarm_hit = (cmp_a == alarm_a) && (cmp_b == alarm_b) &&
                      ({alarm_a, alarm_b} != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ring_q <= 1'b0;
      else if ((state_q == ST_IDLE) && alarm_hit)
         ring_q <= 1'b1;
      else if ((state_q == ST_GRANT) && grant_q[ALARM_CLR_IDX])
         ring_q <= 1'b0;
   end

   assign ring = ring_q;
`else
   logic unused_alarm;
   assign unused_alarm = ^{cmp_a, cmp_b, alarm_a, alarm_b};
   assign ring = 1'b0;
`endif

   assign grant       = grant_q;
   assign init_active = init_active_q;

endmodule

// File: tb/tb_rtc_mode_arbiter.sv
// Directed self-checking bench for rtc_mode_arbiter; ring expectations follow
// whether RTC_ALARM_EN is defined for the build.
module tb_rtc_mode_arbiter;

`ifdef RTC_ALARM_EN
   localparam logic ALARM_EN = 1'b1;
`else
   localparam logic ALARM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [6:0]  bus_cnt = '0;
   logic [3:0]  req = '0;
   logic [7:0]  addr_init = 8'h5A;
   logic [7:0]  data_init = 8'hC3;
   logic [7:0]  addr_read = 8'h7E;
   logic [31:0] addr_req  = {8'h44, 8'h05, 8'h22, 8'h11};
   logic [31:0] data_req  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
   logic [7:0]  cmp_a = '0, cmp_b = '0, alarm_a = '0, alarm_b = '0;
   logic        init_active, conflict, ring;
   logic [3:0]  grant;

   int checks = 0;
   int failures = 0;

   rtc_mode_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus_if ();

   rtc_mode_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .bus_cnt     (bus_cnt),
      .req         (req),
      .addr_init   (addr_init),
      .data_init   (data_init),
      .addr_read   (addr_read),
      .addr_req    (addr_req),
      .data_req    (data_req),
      .cmp_a       (cmp_a),
      .cmp_b       (cmp_b),
      .alarm_a     (alarm_a),
      .alarm_b     (alarm_b),
      .bus         (bus_if),
      .init_active (init_active),
      .grant       (grant),
      .conflict    (conflict),
      .ring        (ring)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic boundary();
      bus_cnt = 7'h4A;
      step(1);
      bus_cnt = 7'h11;
   endtask

   task automatic test_reset();
      step(1);
      checks++; if (init_active !== 1'b1) begin failures++; $display("FAIL rst_init_active got=%b exp=1", init_active); end
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL rst_grant got=%b exp=0000", grant); end
      checks++; if (conflict !== 1'b0 || ring !== 1'b0) begin failures++; $display("FAIL rst_flags conflict=%b ring=%b exp=0/0", conflict, ring); end
      checks++; if (bus_if.wr_ind !== 1'b0 || bus_if.address !== 8'h5A || bus_if.data !== 8'hC3 || bus_if.data_oe !== 1'b1)
         begin failures++; $display("FAIL rst_bus wr=%b addr=%h data=%h oe=%b exp=0/5a/c3/1", bus_if.wr_ind, bus_if.address, bus_if.data, bus_if.data_oe); end
      reset = 1'b1;
      req = 4'b0011;
      bus_cnt = 7'h4A;
      step(1000);
      checks++; if (grant !== 4'b0000 || conflict !== 1'b0) begin failures++; $display("FAIL init_ignores_req grant=%b conflict=%b exp=0000/0", grant, conflict); end
      req = '0;
      bus_cnt = '0;
      step(33);
      checks++; if (init_active !== 1'b1 || bus_if.address !== 8'h5A) begin failures++; $display("FAIL init_last_cycle init_active=%b addr=%h exp=1/5a", init_active, bus_if.address); end
      step(1);
      checks++; if (init_active !== 1'b0 || bus_if.wr_ind !== 1'b1 || bus_if.address !== 8'h7E || bus_if.data !== 8'h00 || bus_if.data_oe !== 1'b0)
         begin failures++; $display("FAIL idle_entry init_active=%b wr=%b addr=%h data=%h oe=%b exp=0/1/7e/00/0", init_active, bus_if.wr_ind, bus_if.address, bus_if.data, bus_if.data_oe); end
   endtask

   task automatic test_grant();
      req = 4'b0010;
      bus_cnt = 7'h10;
      step(1);
      checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL grant_before_boundary got=%b exp=0000", grant); end
      boundary();
      checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL grant_ch1 got=%b exp=0010", grant); end
      checks++; if (bus_if.address !== 8'h22 || bus_if.data !== 8'hA1 || bus_if.data_oe !== 1'b1 || bus_if.wr_ind !== 1'b0)
         begin failures++; $display("FAIL grant_ch1_bus addr=%h data=%h oe=%b wr=%b exp=22/a1/1/0", bus_if.address, bus_if.data, bus_if.data_oe, bus_if.wr_ind); end
      checks++; if (conflict !== 1'b0) begin failures++; $display("FAIL single_req_conflict got=%b exp=0", conflict); end
   endtask

   task automatic test_conflict();
      req = 4'b0000;
      boundary();
      checks++; if (grant !== 4'b0000 || bus_if.wr_ind !== 1'b1) begin failures++; $display("FAIL release_idle grant=%b wr=%b exp=0000/1", grant, bus_if.wr_ind); end
      req = 4'b0110;
      boundary();
      checks++; if (grant !== 4'b0010 || conflict !== 1'b1) begin failures++; $display("FAIL conflict_pick grant=%b conflict=%b exp=0010/1", grant, conflict); end
      req = 4'b0100;
      boundary();
      checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL handover_ch2 got=%b exp=0100", grant); end
      checks++; if (bus_if.address !== 8'h05 || bus_if.data_oe !== 1'b0 || bus_if.data !== 8'h00)
         begin failures++; $display("FAIL zero_mask_nonzero addr=%h oe=%b data=%h exp=05/0/00", bus_if.address, bus_if.data_oe, bus_if.data); end
      addr_req[23:16] = 8'h00;
      #1;
      checks++; if (bus_if.data_oe !== 1'b1 || bus_if.data !== 8'hA2) begin failures++; $display("FAIL zero_mask_zero oe=%b data=%h exp=1/a2", bus_if.data_oe, bus_if.data); end
      req = 4'b0101;
      boundary();
      checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL no_preempt got=%b exp=0100", grant); end
      req = 4'b1001;
      boundary();
      checks++; if (grant !== 4'b0001 || bus_if.address !== 8'h5A || bus_if.data !== 8'hC3 || bus_if.data_oe !== 1'b1 || bus_if.wr_ind !== 1'b0)
         begin failures++; $display("FAIL soft_reset_grant grant=%b addr=%h data=%h oe=%b wr=%b exp=0001/5a/c3/1/0", grant, bus_if.address, bus_if.data, bus_if.data_oe, bus_if.wr_ind); end
      req = 4'b0000;
      boundary();
      checks++; if (grant !== 4'b0000 || conflict !== 1'b1) begin failures++; $display("FAIL conflict_sticky grant=%b conflict=%b exp=0000/1", grant, conflict); end
   endtask

   task automatic test_alarm();
      step(2);
      checks++; if (ring !== 1'b0) begin failures++; $display("FAIL ring_zero_alarm got=%b exp=0", ring); end
      cmp_a = 8'h30; alarm_a = 8'h30;
      cmp_b = 8'h01; alarm_b = 8'h01;
      step(1);
      checks++; if (ring !== ALARM_EN) begin failures++; $display("FAIL ring_set got=%b exp=%b", ring, ALARM_EN); end
      cmp_a = 8'h31;
      step(2);
      checks++; if (ring !== ALARM_EN) begin failures++; $display("FAIL ring_hold got=%b exp=%b", ring, ALARM_EN); end
      req = 4'b0010;
      boundary();
      step(1);
      checks++; if (ring !== 1'b0 || grant !== 4'b0010) begin failures++; $display("FAIL ring_clear ring=%b grant=%b exp=0/0010", ring, grant); end
      req = 4'b0000;
      boundary();
      step(2);
      checks++; if (ring !== 1'b0) begin failures++; $display("FAIL ring_stays_clear got=%b exp=0", ring); end
   endtask

   task automatic test_reset_mid_grant();
      addr_req[23:16] = 8'h05;
      req = 4'b0100;
      boundary();
      checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL pre_reset_grant got=%b exp=0100", grant); end
      #2 reset = 1'b0;
      #1;
      checks++; if (grant !== 4'b0000 || init_active !== 1'b1 || conflict !== 1'b0 || ring !== 1'b0)
         begin failures++; $display("FAIL async_reset grant=%b init=%b conflict=%b ring=%b exp=0000/1/0/0", grant, init_active, conflict, ring); end
      checks++; if (bus_if.wr_ind !== 1'b0 || bus_if.address !== 8'h5A) begin failures++; $display("FAIL async_reset_bus wr=%b addr=%h exp=0/5a", bus_if.wr_ind, bus_if.address); end
      req = '0;
      bus_cnt = '0;
      step(2);
      reset = 1'b1;
      step(1033);
      checks++; if (init_active !== 1'b1 || bus_if.address !== 8'h5A) begin failures++; $display("FAIL replay_init_last init=%b addr=%h exp=1/5a", init_active, bus_if.address); end
      step(1);
      checks++; if (init_active !== 1'b0 || bus_if.wr_ind !== 1'b1 || bus_if.address !== 8'h7E)
         begin failures++; $display("FAIL replay_idle init=%b wr=%b addr=%h exp=0/1/7e", init_active, bus_if.wr_ind, bus_if.address); end
   endtask

   initial begin
      test_reset();
      test_grant();
      test_conflict();
      test_alarm();
      test_reset_mid_grant();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
